// File: rtl/lcd_pkg.sv
// Shared HD44780 definitions used by both the LCD responder and the LCD initiator.
package lcd_pkg;

  localparam logic [7:0] CmdClear     = 8'h01;
  localparam logic [7:0] CmdHome      = 8'h02;
  localparam logic [7:0] CmdEntry     = 8'h04;
  localparam logic [7:0] CmdDisplay   = 8'h08;
  localparam logic [7:0] CmdShift     = 8'h10;
  localparam logic [7:0] CmdFunction  = 8'h20;
  localparam logic [7:0] CmdCgramAddr = 8'h40;
  localparam logic [7:0] CmdDdramAddr = 8'h80;

  localparam logic [6:0]  Line1Base = 7'h00;
  localparam logic [6:0]  Line2Base = 7'h40;
  localparam int unsigned LineLen   = 40;
  localparam int unsigned DdramSize = 2 * LineLen;
  localparam logic [6:0]  Line1Last = Line1Base + 7'(LineLen - 1);
  localparam logic [6:0]  Line2Last = Line2Base + 7'(LineLen - 1);
  localparam logic [7:0]  CharSpace = 8'h20;

  typedef enum logic [1:0] {StInit, StIdle, StSweep, StWait} lcd_state_e;

  function automatic logic addr_valid(input logic [6:0] a);
    return (a <= Line1Last) || ((a >= Line2Base) && (a <= Line2Last));
  endfunction

  // Packs the two 40-byte lines into a contiguous 0..79 storage index.
  function automatic logic [6:0] addr_to_idx(input logic [6:0] a);
    return a[6] ? (a - (Line2Base - 7'(LineLen))) : a;
  endfunction

  function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == Line1Last) return Line2Base;
      if (a == Line2Last) return Line1Base;
      return a + 7'd1;
    end
    if (a == Line2Base) return Line1Last;
    if (a == Line1Base) return Line2Last;
    return a - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Two-flop synchronizer for the HD44780 bus plus qualified en falling-edge detect.
module lcd_bus_sync (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rs,
  input  logic       i_rw,
  input  logic       i_en,
  input  logic [7:0] i_din,
  output logic       o_rs,
  output logic       o_rw,
  output logic       o_en,
  output logic       o_fall,
  output logic       o_lat_rs,
  output logic       o_lat_rw,
  output logic [7:0] o_lat_din
);

  // Bus vector layout {rs, rw, en, din}; en resets high so no edge is seen until en is low.
  localparam logic [10:0] ResetVal = 11'h100;

  logic [10:0] r_meta;
  logic [10:0] r_sync;
  logic [10:0] r_prev;
  logic        r_armed;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta  <= ResetVal;
      r_sync  <= ResetVal;
      r_prev  <= ResetVal;
      r_armed <= 1'b0;
    end else begin
      r_meta  <= {i_rs, i_rw, i_en, i_din};
      r_sync  <= r_meta;
      r_prev  <= r_sync;
      r_armed <= r_armed | ~r_sync[8];
    end
  end

  // An en pulse already high at reset release never arms, so its trailing edge is dropped.
  assign o_fall    = r_prev[8] & ~r_sync[8] & r_armed;
  assign o_rs      = r_sync[10];
  assign o_rw      = r_sync[9];
  assign o_en      = r_sync[8];
  assign o_lat_rs  = r_prev[10];
  assign o_lat_rw  = r_prev[9];
  assign o_lat_din = r_prev[7:0];

endmodule

// File: rtl/lcd_responder.sv
// HD44780-style LCD controller model: decodes bus transactions, holds DDRAM, emulates busy timing.
module lcd_responder
  import lcd_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES = 4000,
  parameter int unsigned HOME_CYCLES = 164000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs,
  input  logic       rw,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       dout_oe,
  output logic       busy,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_mode,
  output logic       cgram_sel,
  output logic       protocol_err,
  output logic [6:0] addr,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam logic [31:0] BusyLoad = 32'(BUSY_CYCLES) - 32'd1;
  localparam logic [31:0] HomeLoad = 32'(HOME_CYCLES) - 32'd1;
  localparam logic [6:0]  LastIdx  = 7'(DdramSize - 1);

  logic       w_rs, w_rw, w_en, w_fall, w_lat_rs, w_lat_rw;
  logic [7:0] w_lat_din;

  lcd_bus_sync u_bus_sync (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_rs      (rs),
    .i_rw      (rw),
    .i_en      (en),
    .i_din     (din),
    .o_rs      (w_rs),
    .o_rw      (w_rw),
    .o_en      (w_en),
    .o_fall    (w_fall),
    .o_lat_rs  (w_lat_rs),
    .o_lat_rw  (w_lat_rw),
    .o_lat_din (w_lat_din)
  );

  lcd_state_e  r_state, w_state_d;
  logic [31:0] r_cnt, w_cnt_d;
  logic [6:0]  r_sweep, w_sweep_d, r_addr, w_addr_d, w_mem_idx;
  logic        r_disp, w_disp_d, r_cursor, w_cursor_d, r_blink, w_blink_d;
  logic        r_inc, w_inc_d, r_cgram, w_cgram_d, r_err, w_err_d, r_dout_oe, w_dout_oe_d;
  logic [7:0]  r_dout, w_dout_d, w_mem_data;
  logic        w_mem_we, w_busy;
  logic [7:0]  r_ddram [DdramSize];

  assign w_busy = (r_state != StIdle);

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_sweep_d  = r_sweep;
    w_addr_d   = r_addr;
    w_disp_d   = r_disp;
    w_cursor_d = r_cursor;
    w_blink_d  = r_blink;
    w_inc_d    = r_inc;
    w_cgram_d  = r_cgram;
    w_err_d    = r_err;
    w_mem_we   = 1'b0;
    w_mem_idx  = r_sweep;
    w_mem_data = CharSpace;

    case (r_state)
      StInit: begin
        w_state_d = StSweep;
        w_cnt_d   = HomeLoad;
        w_sweep_d = '0;
      end
      StSweep: begin
        w_mem_we = 1'b1;
        if (r_cnt != '0) w_cnt_d = r_cnt - 32'd1;
        if (r_sweep == LastIdx) w_state_d = StWait;
        else                    w_sweep_d = r_sweep + 7'd1;
      end
      StWait: begin
        if (r_cnt == '0) w_state_d = StIdle;
        else             w_cnt_d   = r_cnt - 32'd1;
      end
      default: ;
    endcase

    if (w_fall) begin
      if (w_lat_rw) begin
        if (w_lat_rs) w_addr_d = addr_step(r_addr, r_inc);
      end else if (w_busy) begin
        w_err_d = 1'b1;
      end else if (w_lat_rs) begin
        if (!r_cgram) begin
          w_mem_we   = 1'b1;
          w_mem_idx  = addr_to_idx(r_addr);
          w_mem_data = w_lat_din;
          w_addr_d   = addr_step(r_addr, r_inc);
        end
        w_state_d = StWait;
        w_cnt_d   = BusyLoad;
      end else if (w_lat_din != 8'h00) begin
        // Every non-zero command is busy-producing; clear and home override the load below.
        w_state_d = StWait;
        w_cnt_d   = BusyLoad;
        if ((w_lat_din & CmdDdramAddr) != 8'h00) begin
          w_cgram_d = 1'b0;
          w_addr_d  = addr_valid(w_lat_din[6:0]) ? w_lat_din[6:0] : Line1Base;
          if (!addr_valid(w_lat_din[6:0])) w_err_d = 1'b1;
        end else if ((w_lat_din & CmdCgramAddr) != 8'h00) begin
          w_cgram_d = 1'b1;
        end else if ((w_lat_din & CmdFunction) != 8'h00) begin
          if (!w_lat_din[4]) w_err_d = 1'b1;
        end else if ((w_lat_din & CmdShift) != 8'h00) begin
          if (!w_lat_din[3]) w_addr_d = addr_step(r_addr, w_lat_din[2]);
        end else if ((w_lat_din & CmdDisplay) != 8'h00) begin
          w_disp_d   = w_lat_din[2];
          w_cursor_d = w_lat_din[1];
          w_blink_d  = w_lat_din[0];
        end else if ((w_lat_din & CmdEntry) != 8'h00) begin
          w_inc_d = w_lat_din[1];
        end else if ((w_lat_din & CmdHome) != 8'h00) begin
          w_addr_d = Line1Base;
          w_cnt_d  = HomeLoad;
        end else begin
          w_addr_d  = Line1Base;
          w_inc_d   = 1'b1;
          w_state_d = StSweep;
          w_sweep_d = '0;
          w_cnt_d   = HomeLoad;
        end
      end
    end

    w_dout_oe_d = w_rw & w_en;
    w_dout_d    = 8'h00;
    if (w_dout_oe_d) w_dout_d = w_rs ? r_ddram[addr_to_idx(r_addr)] : {w_busy, r_addr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StInit;
      r_cnt     <= '0;
      r_sweep   <= '0;
      r_addr    <= Line1Base;
      r_disp    <= 1'b0;
      r_cursor  <= 1'b0;
      r_blink   <= 1'b0;
      r_inc     <= 1'b1;
      r_cgram   <= 1'b0;
      r_err     <= 1'b0;
      r_dout    <= 8'h00;
      r_dout_oe <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_sweep   <= w_sweep_d;
      r_addr    <= w_addr_d;
      r_disp    <= w_disp_d;
      r_cursor  <= w_cursor_d;
      r_blink   <= w_blink_d;
      r_inc     <= w_inc_d;
      r_cgram   <= w_cgram_d;
      r_err     <= w_err_d;
      r_dout    <= w_dout_d;
      r_dout_oe <= w_dout_oe_d;
    end
  end

  // DDRAM is deliberately not reset; the INIT sweep fills it.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_ddram[w_mem_idx] <= w_mem_data;
  end

  assign dbg_data     = addr_valid(dbg_addr) ? r_ddram[addr_to_idx(dbg_addr)] : 8'h00;
  assign dout         = r_dout;
  assign dout_oe      = r_dout_oe;
  assign busy         = w_busy;
  assign disp_on      = r_disp;
  assign cursor_on    = r_cursor;
  assign blink_on     = r_blink;
  assign inc_mode     = r_inc;
  assign cgram_sel    = r_cgram;
  assign protocol_err = r_err;
  assign addr         = r_addr;

endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder: sweep, command/data writes, wrap, reads, busy errors, reset.
module tb_lcd_responder;

  localparam int unsigned BusyCycles = 10;
  localparam int unsigned HomeCycles = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rs = 1'b0, rw = 1'b0, en = 1'b0;
  logic [7:0] din = 8'h00;
  logic [6:0] dbg_addr = 7'h00;
  logic [7:0] dout, dbg_data;
  logic       dout_oe, busy, disp_on, cursor_on, blink_on, inc_mode, cgram_sel, protocol_err;
  logic [6:0] addr;

  int n_checks = 0;
  int n_pass   = 0;

  lcd_responder #(
    .BUSY_CYCLES (BusyCycles),
    .HOME_CYCLES (HomeCycles)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs           (rs),
    .rw           (rw),
    .en           (en),
    .din          (din),
    .dout         (dout),
    .dout_oe      (dout_oe),
    .busy         (busy),
    .disp_on      (disp_on),
    .cursor_on    (cursor_on),
    .blink_on     (blink_on),
    .inc_mode     (inc_mode),
    .cgram_sel    (cgram_sel),
    .protocol_err (protocol_err),
    .addr         (addr),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // en high for 3 clocks, then 3 clocks of hold; dout is sampled just before en drops.
  task automatic bus_xfer(input logic i_rs, input logic i_rw, input logic [7:0] i_d,
                          output logic [7:0] o_rd, output logic o_oe);
    @(negedge clk);
    rs = i_rs; rw = i_rw; din = i_d; en = 1'b1;
    repeat (3) @(negedge clk);
    o_rd = dout;
    o_oe = dout_oe;
    en   = 1'b0;
    repeat (3) @(negedge clk);
    rw = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 32'(busy), 32'd0);
  endtask

  task automatic send_cmd(input logic [7:0] d);
    logic [7:0] rd;
    logic       oe;
    bus_xfer(1'b0, 1'b0, d, rd, oe);
    wait_idle($sformatf("idle_after_cmd_%02h", d));
  endtask

  task automatic send_data(input logic [7:0] d);
    logic [7:0] rd;
    logic       oe;
    bus_xfer(1'b1, 1'b0, d, rd, oe);
    wait_idle($sformatf("idle_after_data_%02h", d));
  endtask

  task automatic check_mem(input string tag, input logic [6:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    check_eq(tag, 32'(dbg_data), 32'(exp));
  endtask

  task automatic check_fill(input string tag);
    int bad = 0;
    for (int i = 0; i < 80; i++) begin
      dbg_addr = (i < 40) ? 7'(i) : 7'(i + 24);
      #1;
      if (dbg_data !== 8'h20) bad++;
    end
    check_eq(tag, 32'(bad), 32'd0);
  endtask

  task automatic check_reset_state(input string pfx);
    check_eq({pfx, "_dout"}, 32'(dout), 32'h00);
    check_eq({pfx, "_dout_oe"}, 32'(dout_oe), 32'd0);
    check_eq({pfx, "_busy"}, 32'(busy), 32'd1);
    check_eq({pfx, "_disp_on"}, 32'(disp_on), 32'd0);
    check_eq({pfx, "_cursor_on"}, 32'(cursor_on), 32'd0);
    check_eq({pfx, "_blink_on"}, 32'(blink_on), 32'd0);
    check_eq({pfx, "_inc_mode"}, 32'(inc_mode), 32'd1);
    check_eq({pfx, "_cgram_sel"}, 32'(cgram_sel), 32'd0);
    check_eq({pfx, "_addr"}, 32'(addr), 32'h00);
    check_eq({pfx, "_protocol_err"}, 32'(protocol_err), 32'd0);
  endtask

  // Release reset and confirm busy holds through the full HOME_CYCLES sweep+wait.
  task automatic release_and_sweep(input string pfx);
    int drops = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (HomeCycles) begin
      @(negedge clk);
      if (!busy) drops++;
    end
    check_eq({pfx, "_busy_held"}, 32'(drops), 32'd0);
    wait_idle({pfx, "_idle"});
    check_fill({pfx, "_fill"});
  endtask

  initial begin
    logic [7:0] rd;
    logic       oe;

    #2 rst_n = 1'b0;
    #1 check_reset_state("reset");
    repeat (3) @(negedge clk);
    release_and_sweep("init");

    send_cmd(8'h38);
    send_cmd(8'h0E);
    send_cmd(8'h06);
    send_cmd(8'h80);
    send_data(8'h76);
    send_data(8'h65);
    check_eq("seq_disp_on", 32'(disp_on), 32'd1);
    check_eq("seq_cursor_on", 32'(cursor_on), 32'd1);
    check_eq("seq_blink_on", 32'(blink_on), 32'd0);
    check_eq("seq_inc_mode", 32'(inc_mode), 32'd1);
    check_eq("seq_addr", 32'(addr), 32'h02);
    check_mem("seq_ddram0", 7'h00, 8'h76);
    check_mem("seq_ddram1", 7'h01, 8'h65);
    check_eq("seq_no_err", 32'(protocol_err), 32'd0);

    // Status read right after a data write, while still busy.
    bus_xfer(1'b1, 1'b0, 8'h77, rd, oe);
    bus_xfer(1'b0, 1'b1, 8'h00, rd, oe);
    check_eq("status_dout", 32'(rd), 32'h83);
    check_eq("status_oe", 32'(oe), 32'd1);
    wait_idle("status_idle");
    check_eq("status_no_err", 32'(protocol_err), 32'd0);
    check_eq("oe_low_idle", 32'(dout_oe), 32'd0);

    send_cmd(8'h80);
    bus_xfer(1'b1, 1'b1, 8'h00, rd, oe);
    check_eq("read_dout", 32'(rd), 32'h76);
    check_eq("read_addr_step", 32'(addr), 32'h01);

    send_cmd(8'h40);
    check_eq("cgram_sel_set", 32'(cgram_sel), 32'd1);
    send_data(8'h99);
    check_eq("cgram_addr_kept", 32'(addr), 32'h01);
    check_mem("cgram_ddram_kept", 7'h01, 8'h65);
    send_cmd(8'h80);
    check_eq("cgram_sel_clr", 32'(cgram_sel), 32'd0);

    send_cmd(8'hA7);
    send_data(8'h41);
    send_data(8'h42);
    check_mem("wrap_ddram27", 7'h27, 8'h41);
    check_mem("wrap_ddram40", 7'h40, 8'h42);
    check_eq("wrap_addr", 32'(addr), 32'h41);

    // Second write lands two clocks after the first completes, inside its busy window.
    send_cmd(8'h90);
    bus_xfer(1'b1, 1'b0, 8'h33, rd, oe);
    @(negedge clk);
    bus_xfer(1'b1, 1'b0, 8'h55, rd, oe);
    wait_idle("viol_idle");
    check_eq("viol_err", 32'(protocol_err), 32'd1);
    check_mem("viol_first", 7'h10, 8'h33);
    check_mem("viol_ignored", 7'h11, 8'h20);
    check_eq("viol_addr", 32'(addr), 32'h11);

    send_cmd(8'h04);
    check_eq("dec_inc_mode", 32'(inc_mode), 32'd0);
    send_cmd(8'h80);
    send_data(8'h11);
    check_mem("dec_ddram0", 7'h00, 8'h11);
    check_eq("dec_wrap_addr", 32'(addr), 32'h67);
    send_cmd(8'h14);
    check_eq("shift_wrap_addr", 32'(addr), 32'h00);

    send_cmd(8'h0D);
    check_eq("disp2_disp_on", 32'(disp_on), 32'd1);
    check_eq("disp2_cursor_on", 32'(cursor_on), 32'd0);
    check_eq("disp2_blink_on", 32'(blink_on), 32'd1);

    send_cmd(8'h85);
    send_cmd(8'h01);
    check_eq("clear_inc_mode", 32'(inc_mode), 32'd1);
    check_eq("clear_addr", 32'(addr), 32'h00);
    check_fill("clear_fill");

    send_cmd(8'h85);
    bus_xfer(1'b0, 1'b0, 8'h02, rd, oe);
    repeat (50) @(negedge clk);
    check_eq("home_long_busy", 32'(busy), 32'd1);
    wait_idle("home_idle");
    check_eq("home_addr", 32'(addr), 32'h00);

    send_data(8'h5A);
    send_cmd(8'hE7);
    send_data(8'hA5);
    bus_xfer(1'b0, 1'b0, 8'h01, rd, oe);
    repeat (37) @(negedge clk);
    check_eq("midsweep_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1 check_reset_state("midsweep_reset");
    repeat (2) @(negedge clk);
    release_and_sweep("resweep");

    send_cmd(8'hB0);
    check_eq("oob_err", 32'(protocol_err), 32'd1);
    check_eq("oob_addr", 32'(addr), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_responder.md
LCD_RESPONDER -- requirements
Module: lcd_responder

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 4000, clk cycles busy after any non-clear command or data write (40 us at 100 MHz).
REQ-002 SHALL have parameter HOME_CYCLES, default 164000, clk cycles busy after clear or return-home (1.64 ms).
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have ports rs / rw / en, input, 1 each, HD44780 bus controls, asynchronous to clk.
REQ-006 SHALL have port din, input, 8, bus data from the initiator.
REQ-007 SHALL have ports dout (output, 8, read data) and dout_oe (output, 1, high while rw=1 and en=1).
REQ-008 SHALL have status outputs, 1 bit each: busy, disp_on, cursor_on, blink_on, inc_mode, cgram_sel, and a sticky protocol_err.
REQ-009 SHALL have output addr, 7 bits, the current DDRAM address counter.
REQ-010 SHALL have a debug port: dbg_addr input, 7 bits; dbg_data output, 8 bits, combinational DDRAM read.

Function
REQ-011 SHALL pass rs, rw, en and din through 2-flop synchronizers; en high or low pulses shorter than 3 clk cycles are unsupported.
REQ-012 SHALL latch a transaction on the synchronized en falling edge, using the rs/rw/din sampled on that edge.
REQ-013 SHALL hold DDRAM at 80 bytes: line 1 at 0x00-0x27, line 2 at 0x40-0x67.
REQ-014 SHALL, on rs=0 rw=0, decode by highest set bit of din:
- 0x01 clear: fill DDRAM with 0x20, addr=0, inc_mode=1, HOME_CYCLES.
- 0x02 home: addr=0, HOME_CYCLES.
- 0x04 entry: inc_mode=din[1]; din[0] ignored.
- 0x08 display: disp_on=din[2], cursor_on=din[1], blink_on=din[0].
- 0x10 shift: if din[3]=0, step addr by din[2] (1=+1, 0=-1); display shift is a no-op.
- 0x20 function set: if din[4]=0, set protocol_err.
- 0x40 CGRAM addr: cgram_sel=1.
- 0x80 DDRAM addr: addr=din[6:0], cgram_sel=0; an out-of-map value sets protocol_err and maps to 0x00.
- 0x00: no-op, no busy period.
REQ-015 SHALL, on rs=1 rw=0 with cgram_sel=0, write din to DDRAM[addr] and then step addr per inc_mode; with cgram_sel=1, discard the data with no addr change.
REQ-016 SHALL step addr with wrap: +1 goes 0x27->0x40 and 0x67->0x00; -1 goes 0x40->0x27 and 0x00->0x67.
REQ-017 SHALL, on rs=0 rw=1, drive dout={busy,addr} while dout_oe=1; this read is legal while busy.
REQ-018 SHALL, on rs=1 rw=1, drive dout=DDRAM[addr] and step addr at the en falling edge.
REQ-019 SHALL implement FSM states INIT, IDLE, SWEEP, WAIT:
- INIT->SWEEP after reset.
- IDLE->SWEEP on clear.
- IDLE->WAIT on any other busy-producing op.
- SWEEP (one byte per clk, 80 clks) ->WAIT.
- WAIT counts down ->IDLE.
REQ-020 SHALL hold busy=1 in every state except IDLE; busy rises the clk after the latching edge.
REQ-021 SHALL set protocol_err and ignore any write (rw=0) latched while busy=1; reads while busy are not errors.
REQ-022 SHALL count the SWEEP cycles toward the HOME_CYCLES busy period.

Reset
REQ-023 SHALL, on rst_n=0, asynchronously set:
- dout=0x00, dout_oe=0, busy=1;
- disp_on, cursor_on, blink_on=0;
- inc_mode=1, cgram_sel=0, addr=0x00, protocol_err=0;
- FSM=INIT, counters=0.
REQ-024 SHALL fill DDRAM with 0x20 by the INIT sweep after reset, not by reset of the array.
REQ-025 SHALL abort any sweep, countdown or transaction when reset asserts mid-operation; a partial en pulse spanning reset release is ignored.

Structure
REQ-026 SHALL place the following in shared package lcd_pkg, shared with the LCD initiator:
- command opcode constants;
- line base constants 0x00/0x40 and line length 40;
- FSM state typedef.
REQ-027 SHALL implement the synchronizer plus en edge detect as sub-module lcd_bus_sync.

Verification
REQ-028 SHALL verify the post-reset sweep: release rst_n with BUSY_CYCLES=10, HOME_CYCLES=100 -> busy=1 for 100+ clks, then every DDRAM byte reads 0x20 on dbg_data.
REQ-029 SHALL verify the init write sequence: commands 0x38, 0x0E, 0x06, 0x80, then data 0x76, 0x65 -> disp_on=1, cursor_on=1, blink_on=0, DDRAM[0]=0x76, DDRAM[1]=0x65, addr=0x02.
REQ-030 SHALL verify wrap: command 0xA7, then data 0x41 then 0x42 -> DDRAM[0x27]=0x41, DDRAM[0x40]=0x42, addr=0x41.
REQ-031 SHALL verify busy violation: data 0x55 issued 2 clks after a prior write completes -> write ignored, protocol_err=1.
REQ-032 SHALL verify reads: rs=0 rw=1 during busy gives dout[7]=1 and dout[6:0]=addr; rs=1 rw=1 at addr 0x00 holding 0x76 gives dout=0x76 and then addr=0x01.
REQ-033 SHALL verify reset mid-sweep: assert rst_n=0 at sweep cycle 40 after 0x01 -> outputs at reset values, and a full INIT sweep re-runs.
